combo_recorder: RTL and testbench
=================================

# combo_recorder

Programs a new unlock combination from the same debounced, single-pulse `nwse` button stream that the lock state machine consumes. It is the writer side of the combination register: the lock reads `code`, and this block captures, confirms and commits it. It sits beside the lock FSM in the top level, fed by the per-button debounce/pulse chain, with `phase` available for LED/RGB feedback.

## Interface
- `CODE_LEN`, 4: number of button presses in a combination (2..8).
- `TIMEOUT_CYCLES`, 100_000_000: maximum idle clocks between presses while entering or confirming.
- `DEFAULT_CODE`, 8'hE4: value of `code` after reset; width 2*CODE_LEN.
- `clk`  in  1: system clock; the block uses one clock.
- `rst`  in  1: synchronous, active-high reset.
- `nwse`  in  4: one-cycle button pulses; bit3=N, bit2=W, bit1=S, bit0=E.
- `program_en`  in  1: level; high requests and holds programming mode.
- `code`  out  2*CODE_LEN: committed combination; digit i at [2i+1:2i], first press in the LSBs.
- `code_valid`  out  1: 1 once any user code has been committed.
- `phase`  out  2: 0=IDLE, 1=ENTER, 2=CONFIRM, 3=HOLD.
- `done`  out  1: one-cycle pulse on a successful commit.
- `err`  out  1: one-cycle pulse on abort, mismatch, timeout or illegal press.

## Operation
- Digit encoding: the index of the set bit (E=0, S=1, W=2, N=3). A press is any nonzero `nwse`. A press is illegal if more than one bit is set.
- IDLE: `program_en`=1 -> ENTER; clear the index, timer and mismatch flag.
- ENTER: each legal press writes `shadow[idx]` and increments idx. The CODE_LEN-th press -> CONFIRM; idx=0, timer cleared.
- CONFIRM: each legal press is compared with `shadow[idx]`, and any difference sets a sticky mismatch flag. On the CODE_LEN-th press:
  - no mismatch: `code`<=shadow (including the final digit check), `code_valid`<=1, `done` pulse, -> HOLD.
  - mismatch: `err` pulse, `code` unchanged, -> HOLD.
- HOLD: ignore `nwse`; `program_en`=0 -> IDLE. This prevents immediate re-entry.
- Error exits from ENTER or CONFIRM, each pulsing `err` with `code` unchanged:
  - illegal press: -> HOLD.
  - timeout: -> HOLD.
  - `program_en`=0: -> IDLE.
- Priority within one cycle, highest first: `rst`, `program_en` low, illegal press, legal press, timeout.
- Timer: width $clog2(TIMEOUT_CYCLES+1).
  - Clears on state entry and on every legal press; otherwise increments in ENTER/CONFIRM.
  - Timeout fires when the timer equals TIMEOUT_CYCLES-1 with no press that cycle.
- `nwse` is ignored in IDLE and HOLD.

## Timing
- Reset values: `code`=DEFAULT_CODE, `code_valid`=0, `phase`=0, `done`=0, `err`=0. Shadow, idx, timer and flag are cleared.
- Reset mid-programming discards everything, including a previously committed code.
- All outputs are registered. `phase` changes the cycle after the triggering input is sampled.
- `done` and `err` go high exactly one cycle after the final press or error condition, for one cycle. They are never both high.
- `code` and `code_valid` update in the same cycle `done` rises.
- Presses on consecutive cycles are all accepted; no dead time is required.
- Timeout: the error is sampled TIMEOUT_CYCLES clocks after the last clear, so `err` appears on the next cycle.

## Test plan
(CODE_LEN=4, TIMEOUT_CYCLES=20, DEFAULT_CODE=8'hE4)
- Reset: check `code`=8'hE4, `code_valid`=0, `phase`=0. Then `program_en`=1 -> `phase`=1 next cycle.
- Successful program: enter N,W,S,E and confirm N,W,S,E, with 3-cycle gaps -> `done` one cycle after the 8th press, `code`=8'h1B, `code_valid`=1, `phase`=3. Drop `program_en` -> `phase`=0.
- Mismatch: enter N,N,N,N and confirm N,N,E,N -> `err` after the 8th press; `code` stays 8'hE4, `done` never asserts.
- Timeout: two presses, then 20 idle cycles -> `err` pulse, `phase`=3. A 19-cycle gap followed by a press does not time out.
- Abort and illegal press, each case checking `code` is unchanged:
  - drop `program_en` during CONFIRM -> `err`, `phase`=0.
  - `nwse`=4'b0101 during ENTER -> `err`, `phase`=3.
- Back-to-back and reset:
  - 8 presses on consecutive cycles commit correctly.
  - after a commit, `rst` during a new CONFIRM restores `code`=8'hE4 and `code_valid`=0.

Source files
------------

// File: rtl/combo_recorder.sv
// Combination writer: captures a code from debounced nwse pulses, asks for it again,
// and commits it to `code` only when both entries agree.
module combo_recorder #(
    parameter int                    CODE_LEN       = 4,
    parameter int                    TIMEOUT_CYCLES = 100_000_000,
    parameter logic [2*CODE_LEN-1:0] DEFAULT_CODE   = 8'hE4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              nwse,
    input  logic                    program_en,
    output logic [2*CODE_LEN-1:0]   code,
    output logic                    code_valid,
    output logic [1:0]              phase,
    output logic                    done,
    output logic                    err
);

    localparam int IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ENTER   = 2'd1;
    localparam logic [1:0] S_CONFIRM = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [1:0]              r_phase;
    logic [IDX_W-1:0]        r_idx;
    logic [TMR_W-1:0]        r_timer;
    logic                    r_mismatch;
    logic [2*CODE_LEN-1:0]   r_shadow;
    logic [2*CODE_LEN-1:0]   r_code;
    logic                    r_code_valid;
    logic                    r_done;
    logic                    r_err;

    logic                    w_press;
    logic                    w_legal;
    logic                    w_illegal;
    logic [1:0]              w_digit;
    logic                    w_last;
    logic                    w_digit_diff;
    logic                    w_timeout;

    // A legal press has exactly one bit set: clearing the lowest set bit leaves zero.
    assign w_press      = |nwse;
    assign w_legal      = w_press && ((nwse & (nwse - 4'd1)) == 4'd0);
    assign w_illegal    = w_press && !w_legal;
    assign w_last       = (r_idx == LAST_IDX);
    assign w_digit_diff = (r_shadow[{r_idx, 1'b0} +: 2] != w_digit);
    assign w_timeout    = (r_timer == TMR_LAST);

    always_comb begin
        w_digit = 2'd0;
        case (nwse)
            4'b0010: w_digit = 2'd1;
            4'b0100: w_digit = 2'd2;
            4'b1000: w_digit = 2'd3;
            default: w_digit = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= S_IDLE;
            r_idx        <= '0;
            r_timer      <= '0;
            r_mismatch   <= 1'b0;
            r_shadow     <= '0;
            r_code       <= DEFAULT_CODE;
            r_code_valid <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_phase)
                S_IDLE: begin
                    if (program_en) begin
                        r_phase    <= S_ENTER;
                        r_idx      <= '0;
                        r_timer    <= '0;
                        r_mismatch <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!program_en) begin
                        r_phase <= S_IDLE;
                    end
                end
                default: begin
                    // ENTER and CONFIRM share the abort / illegal / timeout exits.
                    if (!program_en) begin
                        r_err   <= 1'b1;
                        r_phase <= S_IDLE;
                    end else if (w_illegal) begin
                        r_err   <= 1'b1;
                        r_phase <= S_HOLD;
                    end else if (w_legal) begin
                        r_timer <= '0;
                        if (r_phase == S_ENTER) begin
                            r_shadow[{r_idx, 1'b0} +: 2] <= w_digit;
                            if (w_last) begin
                                r_phase <= S_CONFIRM;
                                r_idx   <= '0;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end else if (w_last) begin
                            r_phase <= S_HOLD;
                            if (r_mismatch || w_digit_diff) begin
                                r_err <= 1'b1;
                            end else begin
                                r_code       <= r_shadow;
                                r_code_valid <= 1'b1;
                                r_done       <= 1'b1;
                            end
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_mismatch <= r_mismatch | w_digit_diff;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_phase <= S_HOLD;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
            endcase
        end
    end

    assign code       = r_code;
    assign code_valid = r_code_valid;
    assign phase      = r_phase;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_combo_recorder.sv
// Bench for combo_recorder: directed vector table, hand-written corner sequences,
// then random traffic compared each cycle against a queue-based reference model.
module tb_combo_recorder;

    localparam int         CL  = 4;
    localparam int         TO  = 20;
    localparam int         W   = 2 * CL;
    localparam logic [7:0] DEF = 8'hE4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         program_en = 1'b0;
    logic [3:0]   nwse = 4'd0;
    logic [W-1:0] code;
    logic         code_valid;
    logic [1:0]   phase;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    combo_recorder #(
        .CODE_LEN       (CL),
        .TIMEOUT_CYCLES (TO),
        .DEFAULT_CODE   (DEF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .nwse       (nwse),
        .program_en (program_en),
        .code       (code),
        .code_valid (code_valid),
        .phase      (phase),
        .done       (done),
        .err        (err)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_done_seen = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: press history kept as digit queues, idle time as a plain count.
    logic [1:0]   m_phase;
    logic [W-1:0] m_code;
    logic         m_valid;
    logic         m_done;
    logic         m_err;
    int           m_ent[$];
    int           m_cnf[$];
    int           m_idle;

    typedef struct {
        logic         r;
        logic         pen;
        logic [3:0]   b;
        logic [1:0]   ph;
        logic [W-1:0] c;
        logic         v;
        logic         d;
        logic         e;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_step(input logic r, input logic pen, input logic [3:0] b);
        int  ones;
        int  d;
        logic same;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (r) begin
            m_phase = 2'd0;
            m_code  = DEF;
            m_valid = 1'b0;
            m_ent.delete();
            m_cnf.delete();
            m_idle  = 0;
        end else if (m_phase == 2'd0) begin
            if (pen) begin
                m_phase = 2'd1;
                m_ent.delete();
                m_cnf.delete();
                m_idle  = 0;
            end
        end else if (m_phase == 2'd3) begin
            if (!pen) m_phase = 2'd0;
        end else begin
            ones = $countones(b);
            if (!pen) begin
                m_err   = 1'b1;
                m_phase = 2'd0;
            end else if (ones > 1) begin
                m_err   = 1'b1;
                m_phase = 2'd3;
            end else if (ones == 1) begin
                d = 0;
                for (int k = 0; k < 4; k++) if (b[k]) d = k;
                m_idle = 0;
                if (m_phase == 2'd1) begin
                    m_ent.push_back(d);
                    if (m_ent.size() == CL) m_phase = 2'd2;
                end else begin
                    m_cnf.push_back(d);
                    if (m_cnf.size() == CL) begin
                        same = 1'b1;
                        for (int k = 0; k < CL; k++) if (m_ent[k] != m_cnf[k]) same = 1'b0;
                        if (same) begin
                            m_code = '0;
                            for (int k = 0; k < CL; k++) m_code = m_code | (W'(m_ent[k]) << (2 * k));
                            m_valid = 1'b1;
                            m_done  = 1'b1;
                        end else begin
                            m_err = 1'b1;
                        end
                        m_phase = 2'd3;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    m_err   = 1'b1;
                    m_phase = 2'd3;
                end
            end
        end
    endtask

    // One clock: drive, let the edge happen, sample 1ns later, compare with the model.
    task automatic cyc(input logic r, input logic pen, input logic [3:0] b);
        rst = r;
        program_en = pen;
        nwse = b;
        @(posedge clk);
        #1;
        model_step(r, pen, b);
        check("outputs", {19'd0, phase, code, code_valid, done, err},
              {19'd0, m_phase, m_code, m_valid, m_done, m_err});
        if (done) n_done_seen++;
        if (m_done) exp_q.push_back(m_code);
        if (done) begin
            check("sb_pending", exp_q.size(), 1);
            if (exp_q.size() > 0) check("sb_code", {24'd0, code}, {24'd0, exp_q.pop_front()});
        end
    endtask

    function automatic vec_t mk(input logic r, input logic pen, input logic [3:0] b,
                                input logic [1:0] ph, input logic [W-1:0] c,
                                input logic v, input logic d, input logic e);
        vec_t t;
        t.r = r; t.pen = pen; t.b = b; t.ph = ph; t.c = c; t.v = v; t.d = d; t.e = e;
        return t;
    endfunction

    logic [3:0] seq_a[8];
    logic [3:0] seq_f[8];
    logic       rr;
    logic       rp;
    logic [3:0] rb;
    int         k;

    initial begin
        // Back-to-back program N,W,S,E twice, then release and reset.
        tbl[0]  = mk(1'b1, 1'b0, 4'h0, 2'd0, 8'hE4, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 4'h0, 2'd1, 8'hE4, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 4'h8, 2'd1, 8'hE4, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 4'h4, 2'd1, 8'hE4, 1'b0, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 4'h2, 2'd1, 8'hE4, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 4'h1, 2'd2, 8'hE4, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 4'h8, 2'd2, 8'hE4, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 4'h4, 2'd2, 8'hE4, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 4'h2, 2'd2, 8'hE4, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b1, 4'h1, 2'd3, 8'h1B, 1'b1, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b1, 4'h8, 2'd3, 8'h1B, 1'b1, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b0, 4'h0, 2'd0, 8'h1B, 1'b1, 1'b0, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 4'h0, 2'd0, 8'hE4, 1'b0, 1'b0, 1'b0);
        seq_a = '{4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h4, 4'h2, 4'h1};
        seq_f = '{4'h1, 4'h1, 4'h2, 4'h4, 4'h1, 4'h1, 4'h2, 4'h4};

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].r, tbl[i].pen, tbl[i].b);
            check($sformatf("vec%0d", i), {19'd0, phase, code, code_valid, done, err},
                  {19'd0, tbl[i].ph, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].e});
        end

        // Successful program with 3-cycle gaps between presses.
        cyc(1'b0, 1'b1, 4'h0);
        check("pen_enter", {30'd0, phase}, 32'd1);
        n_done_seen = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b1, seq_a[i]);
            repeat (3) cyc(1'b0, 1'b1, 4'h0);
        end
        check("gap_no_early_done", n_done_seen, 0);
        cyc(1'b0, 1'b1, seq_a[7]);
        check("gap_done", {19'd0, done, err, phase, code, code_valid}, {19'd0, 1'b1, 1'b0, 2'd3, 8'h1B, 1'b1});
        cyc(1'b0, 1'b0, 4'h0);
        check("gap_release", {30'd0, phase}, 32'd0);

        // Mismatch: N,N,N,N then N,N,E,N.
        cyc(1'b1, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h0);
        n_done_seen = 0;
        repeat (4) cyc(1'b0, 1'b1, 4'h8);
        cyc(1'b0, 1'b1, 4'h8);
        cyc(1'b0, 1'b1, 4'h8);
        cyc(1'b0, 1'b1, 4'h1);
        cyc(1'b0, 1'b1, 4'h8);
        check("mm_err", {19'd0, done, err, phase, code, code_valid}, {19'd0, 1'b0, 1'b1, 2'd3, 8'hE4, 1'b0});
        check("mm_no_done", n_done_seen, 0);
        cyc(1'b0, 1'b0, 4'h0);

        // Timeout after two presses, and a 19-cycle gap that must survive.
        cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b1, 4'h2);
        cyc(1'b0, 1'b1, 4'h4);
        repeat (TO - 1) cyc(1'b0, 1'b1, 4'h0);
        check("to_not_yet", {30'd0, err, phase}, {29'd0, 1'b0, 2'd1});
        cyc(1'b0, 1'b1, 4'h0);
        check("to_fire", {29'd0, err, phase}, {29'd0, 1'b1, 2'd3});
        cyc(1'b0, 1'b1, 4'h0);
        check("to_one_pulse", {31'd0, err}, 32'd0);
        cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b1, 4'h2);
        repeat (TO - 1) cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b1, 4'h4);
        check("no_to_19", {29'd0, err, phase}, {29'd0, 1'b0, 2'd1});
        cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b0, 4'h0);

        // Abort during CONFIRM.
        cyc(1'b0, 1'b1, 4'h0);
        repeat (4) cyc(1'b0, 1'b1, 4'h1);
        cyc(1'b0, 1'b1, 4'h1);
        cyc(1'b0, 1'b0, 4'h0);
        check("abort", {21'd0, err, done, phase, code}, {21'd0, 1'b1, 1'b0, 2'd0, 8'hE4});

        // Illegal double press during ENTER.
        cyc(1'b0, 1'b1, 4'h0);
        cyc(1'b0, 1'b1, 4'h8);
        cyc(1'b0, 1'b1, 4'b0101);
        check("illegal", {21'd0, err, phase, code}, {21'd0, 1'b1, 2'd3, 8'hE4});
        cyc(1'b0, 1'b1, 4'b0101);
        check("hold_ignores", {29'd0, err, phase}, {29'd0, 1'b0, 2'd3});
        cyc(1'b0, 1'b0, 4'h0);

        // Consecutive-cycle commit, then reset mid-CONFIRM.
        cyc(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, seq_f[i]);
        check("b2b_commit", {22'd0, done, code, code_valid}, {22'd0, 1'b1, 8'h90, 1'b1});
        cyc(1'b0, 1'b0, 4'h0);
        cyc(1'b0, 1'b1, 4'h0);
        repeat (4) cyc(1'b0, 1'b1, 4'h8);
        repeat (2) cyc(1'b0, 1'b1, 4'h8);
        cyc(1'b1, 1'b1, 4'h0);
        check("rst_mid", {19'd0, phase, code, code_valid, done, err}, {19'd0, 2'd0, 8'hE4, 1'b0, 1'b0, 1'b0});
        cyc(1'b0, 1'b0, 4'h0);

        // Random traffic, small digit alphabet so confirms sometimes match.
        for (int s = 0; s < 200; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                repeat (TO + 2) cyc(1'b0, 1'b1, 4'h0);
            end else begin
                repeat (15) begin
                    rr = ($urandom_range(0, 299) == 0);
                    rp = ($urandom_range(0, 99) < 96);
                    k  = $urandom_range(0, 99);
                    if (k < 35)      rb = 4'h0;
                    else if (k < 80) rb = 4'b0001 << $urandom_range(0, 1);
                    else if (k < 93) rb = 4'b0001 << $urandom_range(0, 3);
                    else             rb = 4'($urandom_range(1, 15));
                    cyc(rr, rp, rb);
                end
            end
        end

        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
